ternary_seq_ctrl: RTL

//  Command-driven sequencer for the ternary matrix-vector datapath.

---
 rtl/ternary_pkg.sv | 28 ++
 rtl/tern_seq_cnt.sv | 27 ++
 rtl/ternary_seq_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ternary_pkg.sv
// Shared types for the ternary matrix-vector sequencer.
// State/op encodings and counter width helpers.
package ternary_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLR,
    S_RUN,
    S_DRAIN
  } seq_state_t;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_LOAD = 2'd1,
    OP_RUN  = 2'd2,
    OP_RSVD = 2'd3
  } cmd_op_t;

  function automatic int row_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int col_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tern_seq_cnt.sv
// Saturating index counter with sync clear and last-at-limit flag.
// Holds at limit instead of wrapping.
module tern_seq_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         last
);

  assign last = (count == limit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !last) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ternary_seq_ctrl.sv
// Command sequencer: weight load, MAC run, column drain.
// TERNARY_SEQ_PERF_EN adds a saturating drain-stall counter.
module ternary_seq_ctrl
  import ternary_pkg::*;
#(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8,
  localparam int ROW_W = row_w(MAX_IN_LEN),
  localparam int COL_W = col_w(MAX_OUT_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [ROW_W-1:0] cmd_rows,
  input  logic [COL_W-1:0] cmd_cols,
  input  logic             abort,
  input  logic             data_valid,
  output logic             wload_en,
  output logic [ROW_W-1:0] row_idx,
  output logic             mac_clr,
  output logic             mac_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [COL_W-1:0] drain_col,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [15:0]      perf_stall
);

  seq_state_t       state;
  logic [ROW_W-1:0] rows;
  logic [COL_W-1:0] cols;
  logic             loaded;
  logic             row_last;
  logic             col_last;
  logic             row_phase;
  logic             cmd_acc;

  assign row_phase = (state == S_LOAD) || (state == S_RUN);
  assign cmd_ready = (state == S_IDLE) && !abort;
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign wload_en  = (state == S_LOAD) && data_valid;
  assign mac_en    = (state == S_RUN) && data_valid;
  assign mac_clr   = (state == S_CLR);
  assign out_valid = (state == S_DRAIN);
  assign busy      = (state != S_IDLE);

  tern_seq_cnt #(.W(ROW_W)) u_row (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (abort || !row_phase),
    .en    (row_phase && data_valid),
    .limit (rows),
    .count (row_idx),
    .last  (row_last)
  );

  tern_seq_cnt #(.W(COL_W)) u_col (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (abort || (state != S_DRAIN)),
    .en    ((state == S_DRAIN) && out_ready),
    .limit (cols),
    .count (drain_col),
    .last  (col_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      rows   <= ROW_W'(MAX_IN_LEN - 1);
      cols   <= COL_W'(MAX_OUT_LEN - 1);
      loaded <= 1'b0;
      err    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        if (state == S_LOAD) loaded <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cmd_acc) begin
              case (cmd_op_t'(cmd_op))
                OP_NOP: ;
                OP_LOAD: begin
                  state <= S_LOAD;
                  rows  <= cmd_rows;
                  cols  <= cmd_cols;
                  err   <= 1'b0;
                end
                OP_RUN: begin
                  if (loaded) state <= S_CLR;
                  else        err   <= 1'b1;
                end
                default: err <= 1'b1;
              endcase
            end
          end
          S_LOAD: begin
            if (data_valid && row_last) begin
              state  <= S_IDLE;
              loaded <= 1'b1;
              done   <= 1'b1;
            end
          end
          S_CLR: state <= S_RUN;
          S_RUN: begin
            if (data_valid && row_last) state <= S_DRAIN;
          end
          S_DRAIN: begin
            if (out_ready && col_last) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef TERNARY_SEQ_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (cmd_acc && (cmd_op == OP_RUN)) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign perf_stall = stall_q;
`else
  assign perf_stall = 16'h0;
`endif

endmodule
